balance_arbiter: RTL and testbench

BALANCE_ARBITER -- requirements
Module: balance_arbiter

---
 rtl/cajero_pkg.sv | 20 ++
 rtl/balance_arbiter_if.sv | 35 +++
 rtl/rr_arbiter_2.sv | 39 +++
 rtl/balance_arbiter.sv | 148 ++++++++++++++
 tb/tb_balance_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cajero_pkg.sv
// Shared definitions for the two-terminal balance arbiter: FSM encoding,
// default widths and the transaction-type encoding.
package cajero_pkg;

    localparam int MONTO_W_DEF = 32;
    localparam int BAL_W_DEF   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        DEPOSITO = 1'b0,
        RETIRO   = 1'b1
    } tipo_e;

endpackage

// File: rtl/balance_arbiter_if.sv
// Terminal-side bus of the balance arbiter: load port, per-terminal requests
// and operands, grant/ack handshake and the result pulses.
interface balance_arbiter_if #(
    parameter int MONTO_W = 32,
    parameter int BAL_W   = 64
);
    logic               load_stb;
    logic [BAL_W-1:0]   balance_inicial;
    logic [1:0]         req;
    logic               tipo_trans_0;
    logic               tipo_trans_1;
    logic [MONTO_W-1:0] monto_0;
    logic [MONTO_W-1:0] monto_1;
    logic [1:0]         gnt;
    logic [1:0]         ack;
    logic [BAL_W-1:0]   balance_actualizado;
    logic               balance_stb;
    logic               entregar_dinero;
    logic               fondos_insuficientes;
    logic               desborde;

    modport master (
        output load_stb, balance_inicial, req,
        output tipo_trans_0, tipo_trans_1, monto_0, monto_1,
        input  gnt, ack, balance_actualizado, balance_stb,
        input  entregar_dinero, fondos_insuficientes, desborde
    );

    modport slave (
        input  load_stb, balance_inicial, req,
        input  tipo_trans_0, tipo_trans_1, monto_0, monto_1,
        output gnt, ack, balance_actualizado, balance_stb,
        output entregar_dinero, fondos_insuficientes, desborde
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-request round-robin selector; remembers the last terminal served and
// favours the other one when both request.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       winner,
    output logic       valid
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = update ? served : last_q;
    end

    // Reset value 1 means "terminal 1 served last", so terminal 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        valid = |req;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/balance_arbiter.sv
// Shared-account arbiter: two terminals compete round-robin for one balance
// register; each granted transaction runs GRANT -> EXEC -> RESP.
module balance_arbiter
    import cajero_pkg::*;
#(
    parameter int MONTO_W = MONTO_W_DEF,
    parameter int BAL_W   = BAL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    balance_arbiter_if.slave bus
);

    state_e             state_q, state_d;
    logic               winner_q, winner_d;
    tipo_e              tipo_q, tipo_d;
    logic [MONTO_W-1:0] monto_q, monto_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         ack_q, ack_d;
    logic               bstb_q, bstb_d;
    logic               entregar_q, entregar_d;
    logic               fondos_q, fondos_d;
    logic               desborde_q, desborde_d;

    logic               rr_winner;
    logic               rr_valid;
    logic               rr_update;

    logic [BAL_W-1:0]   monto_ext;
    logic [BAL_W:0]     sum;
    logic [BAL_W-1:0]   diff;
    logic               fits;

    rr_arbiter_2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.req),
        .update (rr_update),
        .served (winner_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    always_comb begin
        monto_ext = BAL_W'(monto_q);
        sum       = {1'b0, balance_q} + {1'b0, monto_ext};
        diff      = balance_q - monto_ext;
        fits      = (monto_ext <= balance_q);
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        tipo_d     = tipo_q;
        monto_d    = monto_q;
        balance_d  = balance_q;
        gnt_d      = '0;
        ack_d      = '0;
        bstb_d     = 1'b0;
        entregar_d = 1'b0;
        fondos_d   = 1'b0;
        desborde_d = 1'b0;
        rr_update  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load_stb) begin
                    balance_d = bus.balance_inicial;
                end else if (rr_valid) begin
                    winner_d         = rr_winner;
                    tipo_d           = tipo_e'(rr_winner ? bus.tipo_trans_1 : bus.tipo_trans_0);
                    monto_d          = rr_winner ? bus.monto_1 : bus.monto_0;
                    gnt_d[rr_winner] = 1'b1;
                    state_d          = GRANT;
                end
            end
            GRANT: begin
                gnt_d[winner_q] = 1'b1;
                state_d         = EXEC;
            end
            EXEC: begin
                // Result flags are computed here so they leave as registered pulses in RESP.
                ack_d[winner_q] = 1'b1;
                bstb_d          = 1'b1;
                state_d         = RESP;
                if (tipo_q == RETIRO) begin
                    if (fits) begin
                        balance_d  = diff;
                        entregar_d = 1'b1;
                    end else begin
                        fondos_d = 1'b1;
                    end
                end else if (sum[BAL_W]) begin
                    desborde_d = 1'b1;
                end else begin
                    balance_d = sum[BAL_W-1:0];
                end
            end
            RESP: begin
                rr_update = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            winner_q   <= 1'b0;
            tipo_q     <= DEPOSITO;
            monto_q    <= '0;
            balance_q  <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            bstb_q     <= 1'b0;
            entregar_q <= 1'b0;
            fondos_q   <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            tipo_q     <= tipo_d;
            monto_q    <= monto_d;
            balance_q  <= balance_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            bstb_q     <= bstb_d;
            entregar_q <= entregar_d;
            fondos_q   <= fondos_d;
            desborde_q <= desborde_d;
        end
    end

    assign bus.gnt                  = gnt_q;
    assign bus.ack                  = ack_q;
    assign bus.balance_actualizado  = balance_q;
    assign bus.balance_stb          = bstb_q;
    assign bus.entregar_dinero      = entregar_q;
    assign bus.fondos_insuficientes = fondos_q;
    assign bus.desborde             = desborde_q;

endmodule

// File: tb/tb_balance_arbiter.sv
// Self-checking bench for balance_arbiter: a table of transactions driven
// through a scoreboard, plus hand sequences for load priority and reset.
module tb_balance_arbiter;
    import cajero_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    balance_arbiter_if #(.MONTO_W(32), .BAL_W(64)) bus ();

    balance_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    // exp_res = {entregar_dinero, fondos_insuficientes, desborde}
    typedef struct {
        bit          do_load;
        logic [63:0] load_val;
        bit          b2b;
        logic [1:0]  req;
        logic        t0;
        logic [31:0] m0;
        logic        t1;
        logic [31:0] m1;
        int          lat;
        logic [1:0]  exp_ack;
        logic [63:0] exp_bal;
        logic [2:0]  exp_res;
    } vec_t;

    typedef struct {
        logic [1:0]  ack;
        logic [63:0] bal;
        logic [2:0]  res;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [2:0] pulses();
        return {bus.entregar_dinero, bus.fondos_insuficientes, bus.desborde};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        bit   got;
        if (!v.b2b) begin
            bus.req = 2'b00;
            @(negedge clk);
        end
        if (v.do_load) begin
            bus.load_stb        = 1'b1;
            bus.balance_inicial = v.load_val;
            @(negedge clk);
            bus.load_stb = 1'b0;
            check($sformatf("v%0d_load", idx), bus.balance_actualizado, v.load_val);
        end
        bus.req          = v.req;
        bus.tipo_trans_0 = v.t0;
        bus.monto_0      = v.m0;
        bus.tipo_trans_1 = v.t1;
        bus.monto_1      = v.m1;
        e.ack = v.exp_ack;
        e.bal = v.exp_bal;
        e.res = v.exp_res;
        sb.push_back(e);
        got = 1'b0;
        for (int cnt = 1; cnt <= 8 && !got; cnt++) begin
            @(negedge clk);
            if (bus.ack != 2'b00) begin
                got = 1'b1;
                check($sformatf("v%0d_latency", idx), 64'(cnt), 64'(v.lat));
                if (sb.size() == 0) begin
                    check($sformatf("v%0d_sb_empty", idx), 64'd0, 64'd1);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d_ack", idx), 64'(bus.ack), 64'(e.ack));
                    check($sformatf("v%0d_balance", idx), bus.balance_actualizado, e.bal);
                    check($sformatf("v%0d_result", idx), 64'(pulses()), 64'(e.res));
                    check($sformatf("v%0d_bstb", idx), 64'(bus.balance_stb), 64'd1);
                    check($sformatf("v%0d_gnt_resp", idx), 64'(bus.gnt), 64'd0);
                end
            end else begin
                check($sformatf("v%0d_gnt_c%0d", idx, cnt), 64'(bus.gnt),
                      (cnt >= v.lat - 2) ? 64'(v.exp_ack) : 64'd0);
                check($sformatf("v%0d_quiet_c%0d", idx, cnt),
                      64'({pulses(), bus.balance_stb}), 64'd0);
            end
        end
        if (!got) check($sformatf("v%0d_ack_timeout", idx), 64'd0, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 64'd1000, 1'b0, 2'b01, RETIRO,   32'd300, DEPOSITO, 32'd0,
                     3, 2'b01, 64'd700, 3'b100};
        vecs[1]  = '{1'b0, 64'd0, 1'b0, 2'b11, DEPOSITO, 32'd50, RETIRO, 32'd700,
                     3, 2'b10, 64'd0, 3'b100};
        vecs[2]  = '{1'b0, 64'd0, 1'b1, 2'b11, DEPOSITO, 32'd50, RETIRO, 32'd700,
                     4, 2'b01, 64'd50, 3'b000};
        vecs[3]  = '{1'b0, 64'd0, 1'b0, 2'b01, RETIRO, 32'd51, DEPOSITO, 32'd0,
                     3, 2'b01, 64'd50, 3'b010};
        vecs[4]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 2'b10, DEPOSITO, 32'd0, DEPOSITO, 32'd10,
                     3, 2'b10, 64'hFFFF_FFFF_FFFF_FFF6, 3'b001};
        vecs[5]  = '{1'b0, 64'd0, 1'b0, 2'b10, DEPOSITO, 32'd0, DEPOSITO, 32'd9,
                     3, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000};
        vecs[6]  = '{1'b1, 64'd500, 1'b0, 2'b10, DEPOSITO, 32'd0, RETIRO, 32'd500,
                     3, 2'b10, 64'd0, 3'b100};
        vecs[7]  = '{1'b0, 64'd0, 1'b0, 2'b11, DEPOSITO, 32'd7, DEPOSITO, 32'd9,
                     3, 2'b01, 64'd7, 3'b000};
        vecs[8]  = '{1'b0, 64'd0, 1'b1, 2'b11, DEPOSITO, 32'd7, DEPOSITO, 32'd9,
                     4, 2'b10, 64'd16, 3'b000};
        vecs[9]  = '{1'b0, 64'd0, 1'b0, 2'b01, RETIRO, 32'd17, DEPOSITO, 32'd0,
                     3, 2'b01, 64'd16, 3'b010};
        vecs[10] = '{1'b0, 64'd0, 1'b0, 2'b01, DEPOSITO, 32'hFFFF_FFFF, DEPOSITO, 32'd0,
                     3, 2'b01, 64'h0000_0001_0000_000F, 3'b000};

        bus.load_stb        = 1'b0;
        bus.balance_inicial = '0;
        bus.req             = 2'b00;
        bus.tipo_trans_0    = 1'b0;
        bus.tipo_trans_1    = 1'b0;
        bus.monto_0         = '0;
        bus.monto_1         = '0;

        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_balance", bus.balance_actualizado, 64'd0);
        check("rst_pulses", 64'({pulses(), bus.balance_stb}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Load and request in the same IDLE cycle; then a load during EXEC.
        bus.req = 2'b00;
        @(negedge clk);
        bus.load_stb        = 1'b1;
        bus.balance_inicial = 64'd200;
        bus.req             = 2'b01;
        bus.tipo_trans_0    = RETIRO;
        bus.monto_0         = 32'd200;
        @(negedge clk);
        bus.load_stb = 1'b0;
        check("ld_pri_gnt", 64'(bus.gnt), 64'd0);
        check("ld_pri_balance", bus.balance_actualizado, 64'd200);
        @(negedge clk);
        check("ld_pri_grant", 64'(bus.gnt), 64'd1);
        @(negedge clk);
        check("ld_pri_exec", 64'(bus.gnt), 64'd1);
        bus.load_stb        = 1'b1;
        bus.balance_inicial = 64'd999;
        @(negedge clk);
        bus.load_stb = 1'b0;
        bus.req      = 2'b00;
        check("ld_pri_ack", 64'(bus.ack), 64'd1);
        check("ld_pri_entregar", 64'(pulses()), 64'b100);
        check("ld_pri_result", bus.balance_actualizado, 64'd0);
        @(negedge clk);
        check("ld_exec_ignored", bus.balance_actualizado, 64'd0);

        // Reset during EXEC, then a pending terminal-1 request.
        bus.load_stb        = 1'b1;
        bus.balance_inicial = 64'd300;
        @(negedge clk);
        bus.load_stb     = 1'b0;
        bus.req          = 2'b01;
        bus.tipo_trans_0 = DEPOSITO;
        bus.monto_0      = 32'd5;
        @(negedge clk);
        @(negedge clk);
        check("rst_exec_gnt_before", 64'(bus.gnt), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_exec_gnt", 64'(bus.gnt), 64'd0);
        check("rst_exec_balance", bus.balance_actualizado, 64'd0);
        check("rst_exec_ack", 64'(bus.ack), 64'd0);
        bus.req          = 2'b10;
        bus.tipo_trans_1 = DEPOSITO;
        bus.monto_1      = 32'd25;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        begin
            bit got = 1'b0;
            for (int cnt = 1; cnt <= 8 && !got; cnt++) begin
                @(negedge clk);
                check($sformatf("post_rst_no_ack0_c%0d", cnt), 64'(bus.ack[0]), 64'd0);
                if (bus.ack != 2'b00) begin
                    got = 1'b1;
                    check("post_rst_latency", 64'(cnt), 64'd3);
                    check("post_rst_ack", 64'(bus.ack), 64'b10);
                    check("post_rst_balance", bus.balance_actualizado, 64'd25);
                    check("post_rst_result", 64'(pulses()), 64'd0);
                end else if (cnt == 1) begin
                    check("post_rst_grant", 64'(bus.gnt), 64'b10);
                end
            end
            if (!got) check("post_rst_ack_timeout", 64'd0, 64'd1);
        end
        bus.req = 2'b00;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
